// File: rtl/fwrisc_muldiv_seq.sv
// rtl/fwrisc_muldiv_seq.sv - sequential MUL/DIVU/REMU engine driving a shared ALU
module fwrisc_muldiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  // ALU operation encodings shared with fwrisc_alu
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LTU = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd15;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_DIVU = 2'b01;
  localparam logic [1:0] MD_REMU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_STEP,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [4:0]  cnt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [31:0] res;
  logic        lt;
  logic        is_rem;
  logic [31:0] rs;
  logic        last_iter;

  // Shifted partial remainder; rem[31] drops off here and is carried as bit 32 via lt
  assign rs        = {rem[30:0], quo[31]};
  assign last_iter = (cnt == 5'd31);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_data  = (state == S_DONE) ? res : 32'd0;

  // Next-state and ALU operand steering
  always_comb begin
    state_n  = state;
    alu_op_a = 32'd0;
    alu_op_b = 32'd0;
    alu_op   = OP_NOP;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          case (in_op)
            MD_MUL:           state_n = S_MUL_STEP;
            MD_DIVU, MD_REMU: state_n = (in_rs2 != 32'd0) ? S_DIV_CMP : S_DONE;
            default:          state_n = S_DONE;
          endcase
        end
      end
      S_MUL_STEP: begin
        alu_op_a = acc;
        alu_op_b = mcand;
        alu_op   = mplier[0] ? OP_ADD : OP_NOP;
        if (last_iter) state_n = S_DONE;
      end
      S_DIV_CMP: begin
        alu_op_a = rs;
        alu_op_b = divisor;
        alu_op   = OP_LTU;
        state_n  = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        alu_op_a = rem;
        alu_op_b = divisor;
        alu_op   = lt ? OP_NOP : OP_SUB;
        state_n  = last_iter ? S_DONE : S_DIV_CMP;
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register and datapath updates; reset discards any operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 5'd0;
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      res     <= 32'd0;
      lt      <= 1'b0;
      is_rem  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt     <= 5'd0;
            acc     <= 32'd0;
            mcand   <= in_rs1;
            mplier  <= in_rs2;
            rem     <= 32'd0;
            quo     <= in_rs1;
            divisor <= in_rs2;
            lt      <= 1'b0;
            is_rem  <= (in_op == MD_REMU);
            case (in_op)
              MD_DIVU: res <= 32'hFFFF_FFFF;
              MD_REMU: res <= in_rs1;
              default: res <= 32'd0;
            endcase
          end
        end
        S_MUL_STEP: begin
          acc    <= alu_out;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last_iter) res <= alu_out;
        end
        S_DIV_CMP: begin
          rem <= rs;
          lt  <= alu_out[0] & ~rem[31];
          quo <= quo << 1;
        end
        S_DIV_SUB: begin
          rem    <= alu_out;
          quo[0] <= ~lt;
          cnt    <= cnt + 5'd1;
          if (last_iter) res <= is_rem ? alu_out : {quo[31:1], ~lt};
        end
        default: ;
      endcase
    end
  end

endmodule
